pingpong_ctrl: RTL and testbench

Write/read sequencer for the two-bank ping-pong sample RAM behind the I2S capture path. It takes the one-cycle sample strobe from the capture block and generates the RAM write port: address, bank select and data. It hands completed banks to a single downstream consumer with a ready/release handshake, and detects overrun when the consumer holds a bank too long.

---
 rtl/pingpong_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pingpong_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_ctrl.sv
// Write/read sequencer for the two-bank ping-pong I2S sample RAM.
// Define PINGPONG_CTRL_DROP_CNT_EN to build the saturating dropped-sample counter.
module pingpong_ctrl #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 24,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              sample_valid_i,
   output logic              ram_we_o,
   output logic [ADDR_W:0]   ram_waddr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [ADDR_W:0]   ram_raddr_o,
   output logic              buffer_ready_o,
   output logic              buffer_bank_o,
   input  logic              release_i,
   output logic              overrun_o,
   output logic [15:0]       drop_cnt_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic              wbank_q, wbank_d;
   logic              we_q, we_d;
   logic [ADDR_W:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic              rbank_q, rbank_d;
   logic              pend_q, pend_d;
   logic              pend_bank_q, pend_bank_d;
   logic              overrun_q, overrun_d;

   logic rel_ok;
   logic held;
   logic last_word;

   assign rel_ok    = release_i & ready_q;
   // The release is applied before the completion check, so a same-cycle release frees the bank.
   assign held      = ready_q & ~release_i;
   assign last_word = &wptr_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      wptr_d      = wptr_q;
      wbank_d     = wbank_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      ready_d     = ready_q;
      rbank_d     = rbank_q;
      pend_d      = 1'b0;
      pend_bank_d = pend_bank_q;
      overrun_d   = overrun_q;

      if (rel_ok) ready_d = 1'b0;
      // A completed bank is shown one cycle after its last write so the word is already in RAM.
      if (pend_q) begin
         ready_d = 1'b1;
         rbank_d = pend_bank_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               state_d = ST_FILL;
               wptr_d  = '0;
            end
         end
         ST_FILL: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
               wptr_d  = '0;
            end else if (sample_valid_i) begin
               we_d    = 1'b1;
               waddr_d = {wbank_q, wptr_q};
               wdata_d = sample_i;
               if (!last_word) begin
                  wptr_d = wptr_q + ADDR_W'(1);
               end else if (!held) begin
                  pend_d      = 1'b1;
                  pend_bank_d = wbank_q;
                  wbank_d     = ~wbank_q;
                  wptr_d      = '0;
               end else begin
                  state_d = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
               wptr_d  = '0;
            end else begin
               if (sample_valid_i) overrun_d = 1'b1;
               if (rel_ok) begin
                  pend_d      = 1'b1;
                  pend_bank_d = wbank_q;
                  wbank_d     = ~wbank_q;
                  wptr_d      = '0;
                  state_d     = ST_FILL;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            wptr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         wbank_q     <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         rbank_q     <= 1'b0;
         pend_q      <= 1'b0;
         pend_bank_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         wbank_q     <= wbank_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rbank_q     <= rbank_d;
         pend_q      <= pend_d;
         pend_bank_q <= pend_bank_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef PINGPONG_CTRL_DROP_CNT_EN
   logic        drop_strobe;
   logic [15:0] drop_cnt_q;

   assign drop_strobe = (state_q == ST_STALL) & enable_i & sample_valid_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         drop_cnt_q <= '0;
      end else if (drop_strobe && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = '0;
`endif

   assign ram_we_o       = we_q;
   assign ram_waddr_o    = waddr_q;
   assign ram_wdata_o    = wdata_q;
   assign ram_raddr_o    = {rbank_q, rd_addr_i};
   assign buffer_ready_o = ready_q;
   assign buffer_bank_o  = rbank_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Self-checking bench for pingpong_ctrl (DEPTH=4): directed test-plan scenarios, then
// random traffic, all compared against a transaction-level model with a publish queue.
module tb_pingpong_ctrl;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 24;
   localparam int AW     = 2;
`ifdef PINGPONG_CTRL_DROP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [DATA_W-1:0] sample;
   logic              sv;
   logic [AW-1:0]     rd_addr;
   logic              rel;
   logic              ram_we;
   logic [AW:0]       ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [AW:0]       ram_raddr;
   logic              buf_ready;
   logic              buf_bank;
   logic              overrun;
   logic [15:0]       drop_cnt;

   always #5 clk = ~clk;

   pingpong_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .enable_i       (en),
      .sample_i       (sample),
      .sample_valid_i (sv),
      .ram_we_o       (ram_we),
      .ram_waddr_o    (ram_waddr),
      .ram_wdata_o    (ram_wdata),
      .rd_addr_i      (rd_addr),
      .ram_raddr_o    (ram_raddr),
      .buffer_ready_o (buf_ready),
      .buffer_bank_o  (buf_bank),
      .release_i      (rel),
      .overrun_o      (overrun),
      .drop_cnt_o     (drop_cnt)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: capture session on/off, fill count, and a queue of banks
   // scheduled to become visible to the consumer at a given edge.
   typedef struct {
      int unsigned due;
      bit          bank;
   } pub_t;
   pub_t pubq[$];

   bit              m_on, m_stalled, m_wbank, m_ready, m_rbank;
   int              m_fill;
   bit              e_we, e_ovr;
   int              e_waddr, e_drops;
   logic [DATA_W-1:0] e_wdata;

   task automatic publish();
      pubq.push_back('{due: cyc + 1, bank: m_wbank});
      m_wbank = !m_wbank;
      m_fill  = 0;
   endtask

   task automatic model_edge();
      bit ready_pre, rel_ok, held;
      cyc++;
      e_we = 1'b0;
      if (!rst_n) begin
         m_on = 0; m_stalled = 0; m_fill = 0; m_wbank = 0;
         m_ready = 0; m_rbank = 0; e_waddr = 0; e_wdata = '0;
         e_ovr = 0; e_drops = 0;
         pubq.delete();
         return;
      end
      ready_pre = m_ready;
      rel_ok    = rel && ready_pre;
      held      = ready_pre && !rel;
      if (rel_ok) m_ready = 0;
      while (pubq.size() > 0 && pubq[0].due == cyc) begin
         m_ready = 1;
         m_rbank = pubq[0].bank;
         void'(pubq.pop_front());
      end
      if (!en) begin
         m_on = 0; m_stalled = 0; m_fill = 0;
      end else if (!m_on) begin
         m_on = 1; m_fill = 0;
      end else if (m_stalled) begin
         if (sv) begin
            e_ovr = 1;
            if (e_drops < 65535) e_drops++;
         end
         if (rel_ok) begin
            m_stalled = 0;
            publish();
         end
      end else if (sv) begin
         e_we    = 1;
         e_waddr = m_wbank * DEPTH + m_fill;
         e_wdata = sample;
         m_fill++;
         if (m_fill == DEPTH) begin
            if (held) m_stalled = 1;
            else      publish();
         end
      end
   endtask

   task automatic compare();
      check("we", 32'(ram_we), 32'(e_we));
      if (e_we) begin
         check("waddr", 32'(ram_waddr), e_waddr);
         check("wdata", 32'(ram_wdata), 32'(e_wdata));
      end
      check("ready", 32'(buf_ready), 32'(m_ready));
      check("bank", 32'(buf_bank), 32'(m_rbank));
      check("overrun", 32'(overrun), 32'(e_ovr));
      check("drop_cnt", 32'(drop_cnt), CNT_EN ? e_drops : 0);
      if (m_ready) check("raddr", 32'(ram_raddr), 32'(m_rbank) * DEPTH + 32'(rd_addr));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic cyc_in(input bit e, input bit v, input logic [DATA_W-1:0] d, input bit r);
      en = e; sv = v; sample = d; rel = r;
      step();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; sv = 1'b0; sample = '0; rd_addr = '0; rel = 1'b0;

      // Reset values
      cyc_in(0, 0, 0, 0);
      cyc_in(0, 0, 0, 0);
      check("rst_we", 32'(ram_we), 0);
      check("rst_waddr", 32'(ram_waddr), 0);
      check("rst_wdata", 32'(ram_wdata), 0);
      check("rst_ready", 32'(buf_ready), 0);
      rst_n = 1'b1;

      // Fill bank 0 with 1..4, ready two cycles after the last strobe
      cyc_in(1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) cyc_in(1, 1, 24'(i), 0);
      check("tp1_last_addr", 32'(ram_waddr), 3);
      cyc_in(1, 0, 0, 0);
      check("tp1_ready", 32'(buf_ready), 1);
      check("tp1_bank", 32'(buf_bank), 0);
      cyc_in(1, 1, 24'd5, 0);
      check("tp1_next_addr", 32'(ram_waddr), 4);

      // Release bank 0, complete bank 1, read address 2 maps to 6
      cyc_in(1, 0, 0, 1);
      check("tp2_ready_drop", 32'(buf_ready), 0);
      for (int i = 6; i <= 8; i++) cyc_in(1, 1, 24'(i), 0);
      rd_addr = 2'd2;
      cyc_in(1, 0, 0, 0);
      check("tp2_bank", 32'(buf_bank), 1);
      check("tp2_raddr", 32'(ram_raddr), 6);

      // Release in the same cycle as a bank's final write: no stall
      for (int i = 9; i <= 11; i++) cyc_in(1, 1, 24'(i), 0);
      cyc_in(1, 1, 24'd12, 1);
      check("tp4_ready_drop", 32'(buf_ready), 0);
      cyc_in(1, 0, 0, 0);
      check("tp4_ready", 32'(buf_ready), 1);
      check("tp4_bank", 32'(buf_bank), 0);
      check("tp4_overrun", 32'(overrun), 0);

      // Bank 0 held, fill bank 1, three strobes dropped, then release
      for (int i = 13; i <= 16; i++) cyc_in(1, 1, 24'(i), 0);
      for (int i = 0; i < 3; i++) begin
         cyc_in(1, 1, 24'(100 + i), 0);
         check("tp3_no_we", 32'(ram_we), 0);
      end
      check("tp3_overrun", 32'(overrun), 1);
      check("tp3_drops", 32'(drop_cnt), CNT_EN ? 3 : 0);
      cyc_in(1, 0, 0, 1);
      check("tp3_ready_drop", 32'(buf_ready), 0);
      cyc_in(1, 0, 0, 0);
      check("tp3_ready", 32'(buf_ready), 1);
      check("tp3_bank", 32'(buf_bank), 1);
      cyc_in(1, 1, 24'd17, 0);
      check("tp3_next_addr", 32'(ram_waddr), 0);

      // Disable mid-fill, re-enable: restart at wptr 0 of the same bank
      cyc_in(1, 0, 0, 1);
      cyc_in(1, 1, 24'd18, 0);
      cyc_in(0, 0, 0, 0);
      cyc_in(0, 1, 24'd19, 0);
      cyc_in(1, 0, 0, 0);
      cyc_in(1, 1, 24'd20, 0);
      check("tp5_restart_addr", 32'(ram_waddr), 0);
      for (int i = 21; i <= 23; i++) cyc_in(1, 1, 24'(i), 0);
      cyc_in(1, 0, 0, 0);
      check("tp5_bank", 32'(buf_bank), 0);
      cyc_in(1, 0, 0, 0);

      // Reset mid-fill while a bank is ready
      cyc_in(1, 1, 24'd30, 0);
      cyc_in(1, 1, 24'd31, 0);
      rst_n = 1'b0;
      cyc_in(1, 1, 24'd32, 0);
      check("tp6_we", 32'(ram_we), 0);
      check("tp6_waddr", 32'(ram_waddr), 0);
      check("tp6_wdata", 32'(ram_wdata), 0);
      check("tp6_ready", 32'(buf_ready), 0);
      check("tp6_overrun", 32'(overrun), 0);
      check("tp6_drops", 32'(drop_cnt), 0);
      rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         rst_n   = ($urandom_range(299) != 0);
         en      = ($urandom_range(99) < 97);
         sv      = ($urandom_range(9) < 6);
         sample  = 24'($urandom);
         rel     = m_ready ? ($urandom_range(99) < 12) : ($urandom_range(99) < 3);
         rd_addr = 2'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
